// File: rtl/sound_pkg.sv
// Shared constants and state encoding for the sound playback controller.
package sound_pkg;

  localparam int DEPTH_WORDS = 512;
  localparam int ADDR_W      = 9;
  localparam int LEVEL_W     = 10;

  typedef enum logic [1:0] {
    ST_FILL,
    ST_READY,
    ST_WAIT1,
    ST_WAIT2
  } play_state_t;

endpackage

// File: rtl/sound_level_cnt.sv
// Byte-to-word assembly tracking, buffered word count and overflow detection.
module sound_level_cnt
  import sound_pkg::*;
#(
  parameter int DEPTH_WORDS = sound_pkg::DEPTH_WORDS
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               frame,
  input  logic               wr_strobe,
  input  logic               commit,
  input  logic               clr_flags,
  output logic [LEVEL_W-1:0] level,
  output logic               drop,
  output logic               overrun
);

  localparam logic [LEVEL_W-1:0] FULL = LEVEL_W'(DEPTH_WORDS);

  logic [1:0] phase;
  logic       word_done;

  // A word completes on the fourth byte; a frame clear swallows the strobe.
  assign word_done = wr_strobe && !frame && (phase == 2'd3);

  // Full buffer with no read draining it: the oldest word is sacrificed.
  assign drop = word_done && !commit && (level == FULL);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      phase   <= 2'd0;
      level   <= '0;
      overrun <= 1'b0;
    end else begin
      if (drop)
        overrun <= 1'b1;
      else if (clr_flags)
        overrun <= 1'b0;

      if (frame) begin
        phase <= 2'd0;
        level <= '0;
      end else begin
        if (wr_strobe)
          phase <= phase + 2'd1;
        if (word_done && !commit && !drop)
          level <= level + 1'b1;
        else if (commit && !word_done)
          level <= level - 1'b1;
      end
    end
  end

endmodule

// File: rtl/sound_play_ctrl.sv
// Playback controller: prefill gating, tick-driven buffer fetch and sticky error flags.
module sound_play_ctrl
  import sound_pkg::*;
#(
  parameter int PREFILL     = 64,
  parameter int DEPTH_WORDS = sound_pkg::DEPTH_WORDS
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               frame,
  input  logic               wr_strobe,
  input  logic               clr_flags,
  input  logic               sample_tick,
  input  logic [31:0]        q,
  output logic [ADDR_W-1:0]  rdaddress,
  output logic [31:0]        sample,
  output logic               sample_valid,
  output logic [LEVEL_W-1:0] level,
  output logic               underrun,
  output logic               overrun
);

  localparam logic [LEVEL_W-1:0] PREFILL_LVL = LEVEL_W'(PREFILL);

  play_state_t       state;
  logic [ADDR_W-1:0] rd_ptr;
  logic              tick_p0;
  logic              tick_empty_p0;
  logic              commit;
  logic              drop;
  logic              underrun_set;

  sound_level_cnt #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_level_cnt (
    .clock     (clock),
    .reset     (reset),
    .frame     (frame),
    .wr_strobe (wr_strobe),
    .commit    (commit),
    .clr_flags (clr_flags),
    .level     (level),
    .drop      (drop),
    .overrun   (overrun)
  );

  assign rdaddress    = rd_ptr;
  assign commit       = (state == ST_WAIT2) && !frame;
  assign underrun_set = (state == ST_READY) && tick_p0 && tick_empty_p0 && !frame;

  // Stage p0: the tick and the emptiness it saw are registered in READY;
  // the FSM acts on them one clock later, so delivery lands 3 clocks after the tick.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= ST_FILL;
      rd_ptr        <= '0;
      tick_p0       <= 1'b0;
      tick_empty_p0 <= 1'b0;
      sample        <= '0;
      sample_valid  <= 1'b0;
      underrun      <= 1'b0;
    end else begin
      sample_valid  <= 1'b0;
      tick_p0       <= 1'b0;
      tick_empty_p0 <= 1'b0;

      if (underrun_set)
        underrun <= 1'b1;
      else if (clr_flags)
        underrun <= 1'b0;

      if (frame) begin
        state  <= ST_FILL;
        rd_ptr <= '0;
      end else begin
        if (commit || drop)
          rd_ptr <= rd_ptr + 1'b1;

        case (state)
          ST_FILL: begin
            if (level >= PREFILL_LVL)
              state <= ST_READY;
          end
          ST_READY: begin
            if (tick_p0)
              state <= tick_empty_p0 ? ST_FILL : ST_WAIT1;
            else if (sample_tick) begin
              tick_p0       <= 1'b1;
              tick_empty_p0 <= (level == '0);
            end
          end
          ST_WAIT1: state <= ST_WAIT2;
          ST_WAIT2: begin
            sample       <= q;
            sample_valid <= 1'b1;
            state        <= ST_READY;
          end
          default: state <= ST_FILL;
        endcase
      end
    end
  end

endmodule
